// File: rtl/sm2_pkg.sv
// Shared constants and state encoding for the SM2 modular reduction stage.
package sm2_pkg;

  localparam int unsigned NARROW_W = 256;
  localparam int unsigned WIDE_W   = 512;

  // p = 2^256 - 2^224 - 2^96 + 2^64 - 1
  localparam logic [NARROW_W-1:0] SM2_P =
    256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;

  // 2^256 mod p = 2^224 + 2^96 - 2^64 + 1
  localparam logic [NARROW_W-1:0] SM2_FOLD_C =
    256'h00000001_00000000_00000000_00000000_00000000_FFFFFFFF_00000000_00000001;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FOLD,
    ST_FINAL,
    ST_OUT
  } state_t;

endpackage

// File: rtl/sm2_fold_unit.sv
// One combinational fold step: val = hi*2^256 + lo  ->  lo + hi*(2^224 + 2^96 - 2^64 + 1).
// When hi is zero the step is the identity.
module sm2_fold_unit
  import sm2_pkg::*;
(
  input  logic [WIDE_W-1:0] val,
  output logic [WIDE_W-1:0] folded
);

  logic [WIDE_W-1:0] hi_ext;
  logic [WIDE_W-1:0] lo_ext;

  // Shift-and-add form of hi*SM2_FOLD_C; the result stays below 2^481, and
  // hi<<96 always exceeds hi<<64, so no wrap or underflow occurs.
  always_comb begin
    hi_ext = {{NARROW_W{1'b0}}, val[WIDE_W-1:NARROW_W]};
    lo_ext = {{NARROW_W{1'b0}}, val[NARROW_W-1:0]};
    folded = lo_ext + (hi_ext << 224) + (hi_ext << 96) - (hi_ext << 64) + hi_ext;
  end

endmodule

// File: rtl/sm2_mod_reduce.sv
// Sequential 512-bit -> 256-bit reduction modulo the SM2 prime.
// Iterative folding followed by one conditional subtraction of p.
// Optional macro SM2_RED_FIXED_LAT_EN: fold runs exactly FOLD_MAX cycles
// (constant latency FOLD_MAX+1); otherwise folding exits early once hi == 0.
module sm2_mod_reduce
  import sm2_pkg::*;
#(
  parameter int unsigned FOLD_MAX = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDE_W-1:0]   prod,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NARROW_W-1:0] res,
  output logic                busy
);

  localparam int unsigned CNT_W = $clog2(FOLD_MAX + 1);

  state_t              state;
  state_t              state_nxt;
  logic [WIDE_W-1:0]   x;
  logic [WIDE_W-1:0]   x_nxt;
  logic [WIDE_W-1:0]   x_fold;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_nxt;
  logic [NARROW_W-1:0] res_nxt;
  logic [NARROW_W-1:0] lo;

  sm2_fold_unit u_fold (
    .val    (x),
    .folded (x_fold)
  );

  assign lo        = x[NARROW_W-1:0];
  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_OUT);
  assign busy      = (state != ST_IDLE);

  // State, working value, fold counter and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      x     <= '0;
      cnt   <= '0;
      res   <= '0;
    end else begin
      state <= state_nxt;
      x     <= x_nxt;
      cnt   <= cnt_nxt;
      res   <= res_nxt;
    end
  end

  // Next-state and datapath selection for accept / fold / final subtract / hold.
  always_comb begin
    state_nxt = state;
    x_nxt     = x;
    cnt_nxt   = cnt;
    res_nxt   = res;
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          x_nxt     = prod;
          cnt_nxt   = '0;
          state_nxt = ST_FOLD;
        end
      end
      ST_FOLD: begin
`ifdef SM2_RED_FIXED_LAT_EN
        // Always fold; with hi == 0 the fold unit returns x unchanged.
        x_nxt   = x_fold;
        cnt_nxt = cnt + CNT_W'(1);
        if (cnt_nxt == CNT_W'(FOLD_MAX)) begin
          state_nxt = ST_FINAL;
        end
`else
        if ((x[WIDE_W-1:NARROW_W] == '0) || (cnt == CNT_W'(FOLD_MAX))) begin
          state_nxt = ST_FINAL;
        end else begin
          x_nxt   = x_fold;
          cnt_nxt = cnt + CNT_W'(1);
        end
`endif
      end
      ST_FINAL: begin
        res_nxt   = (lo >= SM2_P) ? (lo - SM2_P) : lo;
        state_nxt = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sm2_mod_reduce.sv
// Self-checking bench for sm2_mod_reduce: directed table, back-pressure,
// mid-operation reset and randomized products against a mod-p reference.
module tb_sm2_mod_reduce;

  localparam int unsigned FOLD_MAX = 12;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [511:0] prod = '0;
  logic         in_ready;
  logic         out_valid;
  logic         busy;
  logic [255:0] res;

  int n_checks = 0;
  int n_fail   = 0;

  logic [511:0] P;
  logic [511:0] C;

  always #5 clk = ~clk;

  sm2_mod_reduce #(.FOLD_MAX(FOLD_MAX)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .prod      (prod),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .busy      (busy)
  );

  function automatic logic [511:0] pow2(int k);
    logic [511:0] r;
    r = 512'd1;
    return r << k;
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r = {r[479:0], 32'($urandom)};
    return r;
  endfunction

  function automatic logic [255:0] ref_res(logic [511:0] v);
    logic [511:0] r;
    r = v % P;
    return r[255:0];
  endfunction

  // Latency rule: n folds while the upper half is nonzero, then n+2 edges.
  function automatic int ref_lat(logic [511:0] v);
`ifdef SM2_RED_FIXED_LAT_EN
    return int'(FOLD_MAX) + 1;
`else
    logic [511:0] t;
    int n;
    t = v;
    n = 0;
    while (t[511:256] != '0 && n < int'(FOLD_MAX)) begin
      t = {256'd0, t[255:0]} + {256'd0, t[511:256]} * C;
      n++;
    end
    return n + 2;
`endif
  endfunction

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Handshake invariants sampled every cycle outside reset.
  always @(negedge clk) begin
    if (rst_n) begin
      n_checks++;
      if ((in_ready && out_valid) || (busy == in_ready)) begin
        n_fail++;
        $display("FAIL handshake_invariant: in_ready=%0b out_valid=%0b busy=%0b",
                 in_ready, out_valid, busy);
      end
    end
  end

  // Present one product, return the result and accept-to-out_valid edges.
  task automatic do_op(input logic [511:0] v, output logic [255:0] r, output int lat);
    int g;
    g = 0;
    while (!in_ready && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    check("accept_ready", 512'(in_ready), 512'd1);
    in_valid = 1'b1;
    prod     = v;
    @(posedge clk); #1;
    in_valid = 1'b0;
    prod     = rand512();
    check("busy_after_accept", 512'({busy, in_ready}), 512'b10);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("out_valid_seen", 512'(out_valid), 512'd1);
    r = res;
  endtask

  // With out_ready high the result is consumed on the next edge.
  task automatic consume_check(input logic [255:0] r);
    @(posedge clk); #1;
    check("consume_state", 512'({out_valid, in_ready}), 512'b01);
    check("res_held_after_consume", 512'(res), 512'(r));
  endtask

  typedef struct {
    string        name;
    logic [511:0] prod;
    logic [255:0] res;
    int           lat;
  } vec_t;

  vec_t tbl[7];

  initial begin
    logic [255:0] r;
    logic [255:0] r2;
    logic [511:0] v;
    logic [511:0] a;
    logic [511:0] b;
    logic [511:0] pm1;
    logic [511:0] ones;
    int lat;
    int exp_lat;
    int l0;
    int l1;

    P    = pow2(256) - pow2(224) - pow2(96) + pow2(64) - 512'd1;
    C    = pow2(224) + pow2(96) - pow2(64) + 512'd1;
    pm1  = P - 512'd1;
    ones = '1;
`ifdef SM2_RED_FIXED_LAT_EN
    l0 = int'(FOLD_MAX) + 1;
    l1 = int'(FOLD_MAX) + 1;
`else
    l0 = 2;
    l1 = 3;
`endif

    tbl[0] = '{"zero",       512'd0,     256'd0,            l0};
    tbl[1] = '{"p",          P,          256'd0,            l0};
    tbl[2] = '{"p_minus_1",  pm1,        pm1[255:0],        l0};
    tbl[3] = '{"two_256",    pow2(256),  C[255:0],          l1};
    tbl[4] = '{"pm1_squared", pm1 * pm1, 256'd1,            -1};
    tbl[5] = '{"all_ones",   ones,       ref_res(ones),     -1};
    tbl[6] = '{"two_p",      P + P,      256'd0,            -1};

    // Reset state while rst_n is held low.
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 512'({in_ready, out_valid, busy}), 512'b100);
    check("reset_res", 512'(res), 512'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table.
    for (int i = 0; i < 7; i++) begin
      do_op(tbl[i].prod, r, lat);
      exp_lat = (tbl[i].lat >= 0) ? tbl[i].lat : ref_lat(tbl[i].prod);
      check({tbl[i].name, "_res"}, 512'(r), 512'(tbl[i].res));
      check({tbl[i].name, "_lat"}, 512'(lat), 512'(exp_lat));
      consume_check(r);
    end

    // Worst-case latency bound for the all-ones product.
    do_op(ones, r, lat);
`ifdef SM2_RED_FIXED_LAT_EN
    check("all_ones_fixed_lat", 512'(lat), 512'(FOLD_MAX + 1));
`else
    check("all_ones_lat_le_12", 512'(lat <= 12), 512'd1);
`endif
    consume_check(r);

    // Back-pressure: result must hold for 20 stalled cycles.
    out_ready = 1'b0;
    v = rand512();
    do_op(v, r, lat);
    check("bp_res", 512'(r), 512'(ref_res(v)));
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("bp_hold_flags", 512'({out_valid, in_ready}), 512'b10);
      check("bp_hold_res", 512'(res), 512'(ref_res(v)));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release", 512'({out_valid, in_ready}), 512'b01);
    v = rand512();
    do_op(v, r, lat);
    check("bp_next_res", 512'(r), 512'(ref_res(v)));
    check("bp_next_lat", 512'(lat), 512'(ref_lat(v)));
    consume_check(r);

    // Reset in the middle of folding discards the operation.
    do_op(pm1, r, lat);
    consume_check(r);
    in_valid = 1'b1;
    prod     = ones;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("pre_reset_busy", 512'(busy), 512'd1);
    rst_n = 1'b0;
    #1;
    check("mid_reset_outputs", 512'({in_ready, out_valid, busy}), 512'b100);
    check("mid_reset_res", 512'(res), 512'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    v = rand512();
    do_op(v, r, lat);
    check("post_reset_res", 512'(r), 512'(ref_res(v)));
    check("post_reset_lat", 512'(lat), 512'(ref_lat(v)));
    consume_check(r);

    // Randomized products against the reference.
    for (int i = 0; i < 3000; i++) begin
      case (i % 3)
        0: v = rand512();
        1: begin
          a = {256'd0, rand512() >> 256};
          b = {256'd0, rand512() >> 256};
          v = a * b;
        end
        default: begin
          v = rand512();
          v[511:256] = {224'd0, 32'($urandom)};
        end
      endcase
      do_op(v, r2, lat);
      check("rand_res", 512'(r2), 512'(ref_res(v)));
      check("rand_lat", 512'(lat), 512'(ref_lat(v)));
      consume_check(r2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
